// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states, owner codes, byte enables.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_I = 2'b01,
        WAIT_D = 2'b10
    } arb_state_e;

    localparam logic       OWN_I  = 1'b0;
    localparam logic       OWN_D  = 1'b1;
    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating count of data grants issued while fetch waits; at_max forces the next contested grant to fetch.
// Updates one cycle after inc/clr; no handshake, clr wins over inc.
module mem_arb_streak
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int               CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one memory port; data wins unless fetch has been starved.
// Request to m_req 1 cycle, m_ack to x_ack 1 cycle; requesters stall until their ack pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner_d
);

    arb_state_e        state_d, state_q;
    logic              m_req_d, m_req_q;
    logic              m_we_d, m_we_q;
    logic [ADDR_W-1:0] m_addr_d, m_addr_q;
    logic [DATA_W-1:0] m_wdata_d, m_wdata_q;
    logic [3:0]        m_be_d, m_be_q;
    logic              if_ack_d, if_ack_q;
    logic              d_ack_d, d_ack_q;
    logic              owner_d_d, owner_d_q;
    logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
    logic [DATA_W-1:0] d_rdata_d, d_rdata_q;

    logic d_req, if_elig, d_elig, grant_d, grant_i, streak_max;

    // A request line still high during its own ack cycle belongs to the finished access.
    assign d_req   = d_rd | d_wr;
    assign if_elig = if_req & ~if_ack_q;
    assign d_elig  = d_req & ~d_ack_q;
    assign grant_d = (state_q == IDLE) & d_elig & ~(if_elig & streak_max);
    assign grant_i = (state_q == IDLE) & if_elig & ~grant_d;

    mem_arb_streak #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk    (clk),
        .rst    (rst),
        .inc    (grant_d & if_req),
        .clr    (grant_i | (grant_d & ~if_req)),
        .at_max (streak_max)
    );

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        owner_d_d  = owner_d_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d   = WAIT_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_wr;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_be_d    = d_wr ? d_be : BE_ALL;
                    owner_d_d = OWN_D;
                end else if (grant_i) begin
                    state_d   = WAIT_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_be_d    = BE_ALL;
                    owner_d_d = OWN_I;
                end
            end
            WAIT_I: begin
                if (m_ack) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    if_rdata_d = m_rdata;
                    if_ack_d   = 1'b1;
                end
            end
            WAIT_D: begin
                if (m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    d_ack_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            owner_d_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            owner_d_q  <= owner_d_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign owner_d  = owner_d_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level reference model predicts memory requests and acks.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_rd = 1'b0, d_wr = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy, owner_d;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .owner_d(owner_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mreq_t;
    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } ack_t;
    typedef struct {
        logic        is_d;
        logic [31:0] addr;
    } grant_t;

    mreq_t  exp_mreq[$];
    ack_t   exp_ack[$];
    grant_t glog[$];

    // Reference model: one outstanding access, data preferred unless the streak is exhausted.
    logic        mdl_busy = 0, mdl_own = 0, mdl_we = 0, mdl_ack_i = 0, mdl_ack_d = 0;
    logic [31:0] mdl_if_rdata = 0, mdl_d_rdata = 0;
    int          mdl_streak = 0;

    always @(posedge clk) begin
        mreq_t r;
        ack_t  a;
        logic  ie, de;
        if (rst) begin
            mdl_busy = 0; mdl_own = 0; mdl_we = 0; mdl_ack_i = 0; mdl_ack_d = 0;
            mdl_if_rdata = 0; mdl_d_rdata = 0; mdl_streak = 0;
        end else if (mdl_busy) begin
            mdl_ack_i = 0; mdl_ack_d = 0;
            if (m_ack) begin
                mdl_busy = 0;
                if (!mdl_own) begin
                    mdl_if_rdata = m_rdata;
                    mdl_ack_i = 1;
                    a.is_d = 0; a.rdata = mdl_if_rdata;
                end else begin
                    if (!mdl_we) mdl_d_rdata = m_rdata;
                    mdl_ack_d = 1;
                    a.is_d = 1; a.rdata = mdl_d_rdata;
                end
                exp_ack.push_back(a);
            end
        end else begin
            ie = if_req && !mdl_ack_i;
            de = (d_rd || d_wr) && !mdl_ack_d;
            mdl_ack_i = 0; mdl_ack_d = 0;
            if (de && !(ie && mdl_streak == MAXS)) begin
                mdl_streak = if_req ? ((mdl_streak < MAXS) ? mdl_streak + 1 : MAXS) : 0;
                r.is_d = 1; r.we = d_wr; r.addr = d_addr; r.wdata = d_wdata;
                r.be = d_wr ? d_be : 4'hF;
                mdl_we = d_wr; mdl_own = 1; mdl_busy = 1;
                exp_mreq.push_back(r);
            end else if (ie) begin
                mdl_streak = 0;
                r.is_d = 0; r.we = 0; r.addr = if_addr; r.wdata = 0; r.be = 4'hF;
                mdl_we = 0; mdl_own = 0; mdl_busy = 1;
                exp_mreq.push_back(r);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or an ack.
    logic        prev_req = 0;
    mreq_t       held;
    mreq_t       em;
    ack_t        ea;
    grant_t      g;
    int          run_len = 0, last_run_len = 0;

    always @(negedge clk) begin
        chk("busy", busy, mdl_busy);
        chk("owner_d", owner_d, mdl_own);
        chk("if_ack_pulse", if_ack, mdl_ack_i);
        chk("d_ack_pulse", d_ack, mdl_ack_d);
        if (m_req && !prev_req) begin
            chk("mreq_expected", exp_mreq.size() != 0, 1);
            if (exp_mreq.size() != 0) begin
                em = exp_mreq.pop_front();
                chk("m_we", m_we, em.we);
                chk("m_addr", m_addr, em.addr);
                chk("m_be", m_be, em.be);
                if (em.is_d && em.we) chk("m_wdata", m_wdata, em.wdata);
            end
            held.we = m_we; held.addr = m_addr; held.wdata = m_wdata; held.be = m_be;
            g.is_d = owner_d; g.addr = m_addr;
            glog.push_back(g);
            run_len = 1;
        end else if (m_req) begin
            run_len++;
            chk("hold_m_addr", m_addr, held.addr);
            chk("hold_m_we", m_we, held.we);
            chk("hold_m_be", m_be, held.be);
            chk("hold_m_wdata", m_wdata, held.wdata);
        end
        if (!m_req && prev_req) last_run_len = run_len;
        if (if_ack || d_ack) begin
            chk("ack_expected", exp_ack.size() != 0, 1);
            if (exp_ack.size() != 0) begin
                ea = exp_ack.pop_front();
                chk("ack_owner", d_ack, ea.is_d);
                chk("ack_rdata", ea.is_d ? d_rdata : if_rdata, ea.rdata);
            end
        end
        prev_req = m_req;
    end

    // Memory responder: acks after a chosen delay; can inject acks while the port is idle.
    int          fixed_delay = 1;
    logic        fixed_rdata_en = 0;
    logic [31:0] fixed_rdata = 0;
    logic        spurious_en = 0;
    logic        stray_ack = 0;
    logic        resp_busy = 0;
    int          resp_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_req) begin
                if (!resp_busy) begin
                    resp_busy = 1;
                    resp_cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                end
                if (resp_cnt == 0) begin
                    m_ack = 1;
                    m_rdata = fixed_rdata_en ? fixed_rdata : $urandom;
                    resp_busy = 0;
                end else begin
                    m_ack = 0;
                    m_rdata = $urandom;
                    resp_cnt--;
                end
            end else begin
                resp_busy = 0;
                m_rdata = $urandom;
                if (stray_ack || (spurious_en && $urandom_range(0, 15) == 0)) begin
                    m_ack = 1;
                    stray_ack = 0;
                end else begin
                    m_ack = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int budget, input string name, output int at);
        int n;
        n = 0;
        at = -1;
        while (n < budget) begin
            if ((which == 0 && m_req) || (which == 1 && if_ack) || (which == 2 && d_ack)) begin
                at = cyc;
                break;
            end
            tick();
            n++;
        end
        chk({name, "_seen"}, at >= 0, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || m_req) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, busy, 0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1; if_req = 0; d_rd = 0; d_wr = 0;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        int c0, at, g0, nack, ack1, rise2, kind;
        logic pr;
        #400000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, at, g0, nack, ack1, rise2, kind;
        logic pr;
        tick();
        tick();
        chk("rst_m_req", m_req, 0);     chk("rst_m_we", m_we, 0);
        chk("rst_if_ack", if_ack, 0);   chk("rst_d_ack", d_ack, 0);
        chk("rst_owner_d", owner_d, 0); chk("rst_busy", busy, 0);
        chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_be", m_be, 0);       chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 0;
        tick();

        // Single fetch, memory acks one cycle after m_req.
        fixed_delay = 1; fixed_rdata_en = 1; fixed_rdata = 32'h00500093;
        if_req = 1; if_addr = 32'h100; c0 = cyc;
        wait_for(0, 10, "t1_mreq", at);
        chk("t1_mreq_latency", at - c0, 1);
        chk("t1_m_addr", m_addr, 32'h100);
        chk("t1_m_we", m_we, 0);
        wait_for(1, 10, "t1_ifack", at);
        if_req = 0;
        chk("t1_ack_latency", at - c0, 3);
        chk("t1_if_rdata", if_rdata, 32'h00500093);
        chk("t1_busy_at_ack", busy, 0);
        tick();
        tick();

        // Store and fetch together: data first, then fetch.
        fixed_rdata_en = 0; fixed_delay = -1;
        g0 = glog.size();
        if_req = 1; if_addr = 32'h104;
        d_rd = 1; d_wr = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        wait_for(0, 10, "t2_mreq", at);
        chk("t2_m_we", m_we, 1);
        chk("t2_m_be", m_be, 4'h3);
        chk("t2_m_addr", m_addr, 32'h2000);
        chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
        wait_for(2, 20, "t2_dack", at);
        d_rd = 0; d_wr = 0;
        chk("t2_d_rdata_kept", d_rdata, 0);
        wait_for(1, 20, "t2_ifack", at);
        if_req = 0;
        chk("t2_two_grants", glog.size() >= g0 + 2, 1);
        if (glog.size() >= g0 + 2) begin
            chk("t2_first_is_data", glog[g0].is_d, 1);
            chk("t2_second_is_fetch", glog[g0 + 1].is_d, 0);
            chk("t2_fetch_addr", glog[g0 + 1].addr, 32'h104);
        end
        drain("t2");

        // Starvation guard: fetch backs off only during data ack cycles.
        do_reset();
        g0 = glog.size();
        for (int k = 0; k < 200; k++) begin
            d_rd = 1; d_wr = 0; d_addr = $urandom;
            if_req = !d_ack;
            if (if_ack) if_addr = $urandom;
            tick();
        end
        if_req = 0; d_rd = 0;
        drain("t3");
        chk("t3_enough_grants", glog.size() >= g0 + 15, 1);
        if (glog.size() >= g0 + 15) begin
            for (int k = 0; k < 15; k++) chk("t3_grant_pattern", glog[g0 + k].is_d, (k % 5) != 4);
        end

        // Load request held across its ack: ack cycle issues no grant.
        nack = 0; ack1 = -1; rise2 = -1; pr = m_req;
        d_rd = 1; d_wr = 0; d_addr = 32'h500;
        for (int k = 0; k < 40 && nack < 2; k++) begin
            tick();
            if (m_req && !pr && nack == 1) rise2 = cyc;
            pr = m_req;
            if (d_ack) begin
                nack++;
                if (nack == 1) begin ack1 = cyc; d_addr = 32'h504; end
                else d_rd = 0;
            end
        end
        d_rd = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (d_ack) nack++;
        end
        chk("t4_two_acks", nack, 2);
        chk("t4_regrant_gap", rise2 - ack1, 2);

        // Reset in the middle of a data wait, then a late memory ack.
        fixed_delay = 5;
        d_rd = 1; d_addr = 32'h40;
        wait_for(0, 10, "t5_mreq", at);
        tick();
        rst = 1; d_rd = 0;
        tick();
        rst = 0; stray_ack = 1;
        nack = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (d_ack) nack++;
        end
        chk("t5_no_ack", nack, 0);
        chk("t5_m_req", m_req, 0);
        chk("t5_busy", busy, 0);

        // Slow memory with a wandering data address.
        fixed_delay = 7;
        d_rd = 1; d_addr = 32'h3000;
        wait_for(0, 10, "t6_mreq", at);
        for (int k = 0; k < 20 && !d_ack; k++) begin
            chk("t6_m_addr", m_addr, 32'h3000);
            d_addr = $urandom;
            tick();
        end
        d_rd = 0;
        tick();
        chk("t6_run_len", last_run_len, 8);
        drain("t6");

        // Randomised traffic with spurious acks and occasional resets.
        fixed_delay = -1; spurious_en = 1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if (if_req) begin
                    if (if_ack) begin if_req = $urandom_range(0, 1); if_addr = $urandom; end
                end else if ($urandom_range(0, 2) == 0) begin
                    if_req = 1; if_addr = $urandom;
                end
                if (d_rd || d_wr) begin
                    if (d_ack) begin d_rd = 0; d_wr = 0; end
                end else if ($urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 2);
                    d_rd = (kind != 1); d_wr = (kind != 0);
                    d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
                end
            end
        end
        if_req = 0; d_rd = 0; d_wr = 0; spurious_en = 0;
        drain("t7");
        chk("end_mreq_queue_empty", exp_mreq.size(), 0);
        chk("end_ack_queue_empty", exp_ack.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
